// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - pipelined instruction fetch with PC-tagged return queue and flush
module ifu_fetch_queue #(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [XLEN-1:0]            flush_pc,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [XLEN-1:0]            inst,
   output logic [XLEN-1:0]            inst_pc,
   output logic                       io_ifu_reqValid,
   input  logic                       io_ifu_reqReady,
   output logic [XLEN-1:0]            io_ifu_addr,
   input  logic                       io_ifu_respValid,
   input  logic [XLEN-1:0]            io_ifu_rdata,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH+1);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1);
   localparam int unsigned SW = ((OW > CW) ? OW : CW) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [XLEN-1:0] mem_inst_q [DEPTH];
   logic [XLEN-1:0] mem_pc_q [DEPTH];

   logic [SW-1:0]   live_sum;
   logic            resp_fire;
   logic            accept;
   logic            drop_now;
   logic            push;
   logic            pop;
   logic            unused_flush_bits;

   // Instruction alignment is implied; the low target bits carry no information.
   assign unused_flush_bits = ^flush_pc[1:0];

   // Queue slots already taken plus live (not-to-be-dropped) requests; a request
   // only issues if its response is guaranteed a slot.
   assign live_sum        = SW'(occ_q) + SW'(outstanding_q) - SW'(drop_cnt_q);
   assign io_ifu_reqValid = reset && !flush
                            && (outstanding_q < CW'(MAX_OUTSTANDING))
                            && (live_sum < SW'(DEPTH));
   assign io_ifu_addr     = fetch_pc_q;

   assign resp_fire  = io_ifu_respValid && (outstanding_q != '0);
   assign accept     = io_ifu_reqValid && io_ifu_reqReady;
   assign drop_now   = resp_fire && (drop_cnt_q != '0);
   assign push       = resp_fire && !drop_now && !flush;
   assign pop        = inst_valid && inst_ready && !flush;

   assign inst_valid = (occ_q != '0);
   assign inst       = inst_valid ? mem_inst_q[rd_ptr_q] : '0;
   assign inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q] : '0;
   assign occupancy  = occ_q;

   // Next-state: flush overrides everything and turns in-flight requests into drops.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      occ_d         = occ_q;
      if (flush) begin
         fetch_pc_d    = {flush_pc[XLEN-1:2], 2'b00};
         resp_pc_d     = {flush_pc[XLEN-1:2], 2'b00};
         outstanding_d = outstanding_q - CW'(resp_fire);
         drop_cnt_d    = outstanding_q - CW'(resp_fire);
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         occ_d         = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         outstanding_d = outstanding_q + CW'(accept) - CW'(resp_fire);
         if (drop_now) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            resp_pc_d = resp_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         occ_d = occ_q + OW'(push) - OW'(pop);
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
      end
   end

   // Queue storage; contents are only visible through the valid-gated head outputs.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_inst_q[wr_ptr_q] <= io_ifu_rdata;
         mem_pc_q[wr_ptr_q]   <= resp_pc_q;
      end
   end

   resp_without_request: assert property (@(posedge clock) disable iff (!reset)
      !(io_ifu_respValid && (outstanding_q == '0)));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - scoreboard bench for ifu_fetch_queue (two reset PCs)
module tb_ifu_fetch_queue;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [31:0] flush_pc;
   logic        inst_ready;
   logic        req_ready;
   logic        bus_hold;

   logic        inst_valid [2];
   logic [31:0] inst [2];
   logic [31:0] inst_pc [2];
   logic        req_valid [2];
   logic [31:0] addr [2];
   logic        resp_valid [2];
   logic [31:0] rdata [2];
   logic [2:0]  occ [2];

   logic [31:0] exp_q [2][$];
   logic [31:0] rst_pc [2];
   int          acc_cnt [2];
   int          pops [2];
   int          pop_cyc0 [8];
   int          cyc;
   int          checks;
   int          errors;
   int          base;

   ifu_fetch_queue u_dut0 (
      .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
      .inst_valid(inst_valid[0]), .inst_ready(inst_ready), .inst(inst[0]), .inst_pc(inst_pc[0]),
      .io_ifu_reqValid(req_valid[0]), .io_ifu_reqReady(req_ready), .io_ifu_addr(addr[0]),
      .io_ifu_respValid(resp_valid[0]), .io_ifu_rdata(rdata[0]), .occupancy(occ[0])
   );

   ifu_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
      .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
      .inst_valid(inst_valid[1]), .inst_ready(inst_ready), .inst(inst[1]), .inst_pc(inst_pc[1]),
      .io_ifu_reqValid(req_valid[1]), .io_ifu_reqReady(req_ready), .io_ifu_addr(addr[1]),
      .io_ifu_respValid(resp_valid[1]), .io_ifu_rdata(rdata[1]), .occupancy(occ[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push_seq(input logic [31:0] s0, input logic [31:0] s1, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q[0].push_back(s0 + 32'(4 * i));
         exp_q[1].push_back(s1 + 32'(4 * i));
      end
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
         step(1);
         n++;
      end
      chk({name, "_drained"}, 32'(n < 100), 32'd1);
   endtask

   task automatic check_reset(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("%s_inst_valid%0d", tag, g), 32'(inst_valid[g]), 32'd0);
         chk($sformatf("%s_req_valid%0d", tag, g), 32'(req_valid[g]), 32'd0);
         chk($sformatf("%s_addr%0d", tag, g), addr[g], rst_pc[g]);
         chk($sformatf("%s_occ%0d", tag, g), 32'(occ[g]), 32'd0);
         chk($sformatf("%s_inst%0d", tag, g), inst[g], 32'd0);
         chk($sformatf("%s_inst_pc%0d", tag, g), inst_pc[g], 32'd0);
      end
      chk({tag, "_outstanding"}, 32'(u_dut0.outstanding_q), 32'd0);
      chk({tag, "_drop_cnt"}, 32'(u_dut0.drop_cnt_q), 32'd0);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      logic [31:0] pend_q [$];

      // Bus model: answers each accepted request in the following cycle unless held.
      initial begin
         logic        acc;
         logic [31:0] a;
         acc_cnt[g]    = 0;
         resp_valid[g] = 1'b0;
         rdata[g]      = '0;
         forever begin
            @(negedge clock);
            acc = req_valid[g] && req_ready;
            a   = addr[g];
            @(posedge clock);
            #2;
            if (!reset) begin
               pend_q.delete();
               resp_valid[g] = 1'b0;
            end else begin
               if (acc) begin
                  pend_q.push_back(a);
                  acc_cnt[g] = acc_cnt[g] + 1;
               end
               if (!bus_hold && pend_q.size() != 0) begin
                  resp_valid[g] = 1'b1;
                  rdata[g]      = pend_q.pop_front() ^ 32'hFFFF_FFFF;
               end else begin
                  resp_valid[g] = 1'b0;
               end
            end
         end
      end

      // Monitor: every handshake on the core side is matched against the scoreboard.
      initial begin
         logic [31:0] e;
         pops[g] = 0;
         forever begin
            @(negedge clock);
            if (reset && inst_valid[g] && inst_ready && !flush) begin
               if (exp_q[g].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pop%0d: got pc %h, required no instruction", g, inst_pc[g]);
               end else begin
                  e = exp_q[g].pop_front();
                  chk($sformatf("inst_pc%0d", g), inst_pc[g], e);
                  chk($sformatf("inst%0d", g), inst[g], e ^ 32'hFFFF_FFFF);
               end
               if (g == 0 && pops[g] < 8) pop_cyc0[pops[g]] = cyc;
               pops[g] = pops[g] + 1;
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      checks     = 0;
      errors     = 0;
      rst_pc[0]  = 32'h8000_0000;
      rst_pc[1]  = 32'hFFFF_FFF8;
      reset      = 1'b0;
      flush      = 1'b0;
      flush_pc   = '0;
      inst_ready = 1'b0;
      req_ready  = 1'b0;
      bus_hold   = 1'b0;
      step(3);
      check_reset("reset");

      // Linear fetch; lane 1 wraps through address zero.
      req_ready  = 1'b1;
      inst_ready = 1'b1;
      push_seq(32'h8000_0000, 32'hFFFF_FFF8, 8);
      reset      = 1'b1;
      wait_empty("linear");
      inst_ready = 1'b0;
      chk("throughput", 32'(pop_cyc0[7] - pop_cyc0[1]), 32'd6);

      // Backpressure fill.
      reset = 1'b0;
      step(2);
      base  = acc_cnt[0];
      reset = 1'b1;
      step(20);
      chk("bp_accepts", 32'(acc_cnt[0] - base), 32'd4);
      chk("bp_occ0", 32'(occ[0]), 32'd4);
      chk("bp_occ1", 32'(occ[1]), 32'd4);
      chk("bp_req_valid", 32'(req_valid[0]), 32'd0);
      push_seq(32'h8000_0000, 32'hFFFF_FFF8, 1);
      inst_ready = 1'b1;
      step(1);
      inst_ready = 1'b0;
      step(10);
      chk("bp_one_more_accept", 32'(acc_cnt[0] - base), 32'd5);
      chk("bp_occ_refill", 32'(occ[0]), 32'd4);
      chk("bp_popped", 32'(exp_q[0].size()), 32'd0);

      // Flush with two requests in flight.
      bus_hold = 1'b1;
      flush_pc = 32'h8000_0040;
      flush    = 1'b1;
      step(1);
      flush    = 1'b0;
      base     = acc_cnt[0];
      step(6);
      chk("inflight_accepts", 32'(acc_cnt[0] - base), 32'd2);
      chk("inflight_occ", 32'(occ[0]), 32'd0);
      chk("inflight_outstanding", 32'(u_dut0.outstanding_q), 32'd2);
      flush_pc = 32'h8000_0100;
      flush    = 1'b1;
      step(1);
      flush    = 1'b0;
      chk("flush2_drop_cnt", 32'(u_dut0.drop_cnt_q), 32'd2);
      chk("flush2_addr", addr[0], 32'h8000_0100);
      bus_hold   = 1'b0;
      push_seq(32'h8000_0100, 32'h8000_0100, 8);
      inst_ready = 1'b1;
      wait_empty("flush2");
      inst_ready = 1'b0;

      // Flush coinciding with a response and a pop.
      step(10);
      chk("pre_occ_full", 32'(occ[0]), 32'd4);
      bus_hold = 1'b1;
      push_seq(32'h8000_0120, 32'h8000_0120, 2);
      inst_ready = 1'b1;
      wait_empty("pre_flush3");
      inst_ready = 1'b0;
      step(3);
      chk("pre_flush3_outstanding", 32'(u_dut0.outstanding_q), 32'd2);
      chk("pre_flush3_occ", 32'(occ[0]), 32'd2);
      bus_hold   = 1'b0;
      flush_pc   = 32'h8000_0301;
      flush      = 1'b1;
      inst_ready = 1'b1;
      step(1);
      flush      = 1'b0;
      chk("flush3_occ", 32'(occ[0]), 32'd0);
      chk("flush3_drop_cnt", 32'(u_dut0.drop_cnt_q), 32'd1);
      chk("flush3_inst_valid", 32'(inst_valid[0]), 32'd0);
      chk("flush3_addr", addr[0], 32'h8000_0300);
      push_seq(32'h8000_0300, 32'h8000_0300, 4);
      wait_empty("flush3");
      inst_ready = 1'b0;

      // Asynchronous reset mid-traffic, then clean restart.
      step(1);
      @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      check_reset("async_reset");
      step(2);
      push_seq(32'h8000_0000, 32'hFFFF_FFF8, 4);
      inst_ready = 1'b1;
      reset      = 1'b1;
      wait_empty("restart");
      inst_ready = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch front end that replaces the single-request fetch FSM. It keeps up to `MAX_OUTSTANDING` in-order fetch requests in flight on the instruction bus. Returned words are buffered in a `DEPTH`-entry queue tagged with their PC, and the core consumes them through a valid/ready handshake. A core-side `flush` redirects fetch after taken jumps and branches and discards stale in-flight data.

## Interface
- `XLEN`, 32: address and instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered bus requests; 1..`DEPTH`.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.

Ports:
- `clock` in 1: the single clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: redirect fetch to `flush_pc`. Wins over every other event in the same cycle.
- `flush_pc` in XLEN: redirect target; bits [1:0] are ignored and treated as 0.
- `inst_valid` out 1: queue head is valid.
- `inst_ready` in 1: core consumes the head.
- `inst` out XLEN: head instruction word.
- `inst_pc` out XLEN: PC of the head instruction.
- `io_ifu_reqValid` out 1: fetch request.
- `io_ifu_reqReady` in 1: bus accepts the request.
- `io_ifu_addr` out XLEN: fetch address.
- `io_ifu_respValid` in 1: one response, in request order.
- `io_ifu_rdata` in XLEN: response data.
- `occupancy` out clog2(DEPTH+1): valid queue entries.

## Operation
- **Registered state:**
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: in-flight count.
  - `drop_cnt`: responses still to discard.
  - Circular queue of {inst, pc} with read/write pointers and `occupancy`.
- **Request issue:**
  - `io_ifu_reqValid` = !flush && `outstanding` < MAX_OUTSTANDING && `occupancy`+`outstanding`−`drop_cnt` < DEPTH.
  - The term `outstanding`−`drop_cnt` counts only live in-flight requests. This reservation guarantees every kept response has a free slot.
  - `io_ifu_addr` = `fetch_pc` at all times.
  - On acceptance (reqValid && reqReady): `fetch_pc` += 4, modulo 2^XLEN; `outstanding` += 1.
- **Response:**
  - `io_ifu_respValid` decrements `outstanding`.
  - If `drop_cnt` > 0 the word is discarded and `drop_cnt` −= 1.
  - Otherwise {rdata, `resp_pc`} is written at the queue tail and `resp_pc` += 4.
- **Dequeue:** `inst_valid` = `occupancy` ≠ 0. A pop happens on `inst_valid` && `inst_ready`.
- **Simultaneous push and pop:** allowed at any occupancy, including full; `occupancy` is unchanged.
- **Accept and response in the same cycle:** `outstanding` is unchanged.
- **Flush:**
  - Queue emptied; pointers reset; `fetch_pc` and `resp_pc` ← `flush_pc`.
  - `drop_cnt` ← `outstanding` (value before the flush, including any response arriving in the flush cycle), minus 1 if a response arrives that cycle.
  - Any response arriving in the flush cycle is discarded.
  - No request is issued in the flush cycle.
  - Any pop in the flush cycle is ignored.
- **Back-to-back flushes:** each flush recomputes `drop_cnt` from the current `outstanding`; it never accumulates.
- **Protocol error:** `io_ifu_respValid` with `outstanding` = 0 is ignored and leaves state unchanged. Simulation asserts on it.

## Timing
- **Reset (asserted):**
  - `inst_valid` 0, `io_ifu_reqValid` 0, `io_ifu_addr` RESET_PC, `occupancy` 0.
  - `inst` and `inst_pc` 0.
  - `outstanding` and `drop_cnt` 0.
- **Reset mid-operation:** abandons all in-flight requests without drop accounting; the bus must be reset with the block.
- **First request:** `io_ifu_reqValid` rises in the first cycle after reset deasserts.
- **Combinational dependence:**
  - `io_ifu_reqValid` depends only on registers and `flush`, never on `io_ifu_reqReady`.
  - `inst_valid`, `inst` and `inst_pc` are registered-only.
- **Response-to-core latency:** a response in cycle N gives `inst_valid` in cycle N+1 if the queue was empty.
- **Redirect latency:** `flush` in cycle N gives `io_ifu_addr` = `flush_pc` with reqValid high in cycle N+1, subject to the issue condition.
- **Throughput:** one instruction per cycle sustained when the bus answers in ≤ MAX_OUTSTANDING−1 cycles and `inst_ready` is held high.

## Test plan
- **Reset and linear fetch:** reset, then reqReady=1 and respond 1 cycle after each accept with rdata=addr^32'hFFFF_FFFF. Required: core sees `inst_pc` 8000_0000, 8000_0004, 8000_0008 …, each with matching `inst`, one per cycle after warm-up.
- **Backpressure fill:** `inst_ready`=0, DEPTH=4. Required: exactly 4 requests are accepted, `occupancy` reaches 4, reqValid stays 0. Then one pop gives exactly one new request.
- **Flush with 2 in flight:** flush_pc=8000_0100 while 2 requests are outstanding. Required: both responses are dropped; next `inst_pc` is 8000_0100 with the new data; no stale word is ever presented.
- **Flush coinciding with a response and a pop:** required: the response is discarded, `drop_cnt`=`outstanding`−1, `occupancy`=0 next cycle.
- **Wrap-around:** RESET_PC=32'hFFFF_FFF8. Required: `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; queue pointers wrap past DEPTH entries with data intact.
- **Async reset during outstanding traffic:** assert reset mid-burst. Required: all outputs reach reset values immediately, without waiting for a clock edge.
